// File: rtl/m_decoder_operand_stage.sv
// ---------------------------------------------------------------------------
// m_decoder_operand_stage
//
// Registered operand-fetch stage sitting between the decoder and execute.
// It decodes the instruction kind and register fields, reads the register
// file through two combinational read ports, and sign-extends the RRI
// immediate to XLEN. A 32-entry scoreboard tracks destination registers
// whose results are still in flight. A read-after-write hazard on a used
// source either stalls the stage, or, with BYPASS=1, is resolved by taking
// the same-cycle writeback data.
//
// Ports
//   clk             clock
//   reset           synchronous, active-high reset
//   flush           drop the held output and clear the scoreboard
//   in_valid        decoder presents an instruction
//   in_ready        stage accepts this cycle
//   in_kind         instruction kind (e_kind)
//   in_instruction  raw 32-bit instruction
//   rs_sel/rs_in    register-file read port A (select out, data in)
//   rq_sel/rq_in    register-file read port B (select out, data in)
//   wb_en           writeback strobe
//   wb_sel          writeback register
//   wb_data         writeback data
//   out_valid       operands are held for execute
//   out_ready       execute accepts the held operands
//   out_kind        registered instruction kind
//   out_val_a       operand A
//   out_val_b       operand B (register or sign-extended immediate)
//   out_rd          destination register
//
// Parameters
//   XLEN    operand / register data width (must exceed IMM_W)
//   IMM_W   RRI immediate width, taken from in_instruction[IMM_W-1:0], 1..15
//   BYPASS  1 = forward same-cycle writeback into operands, 0 = stall
// ---------------------------------------------------------------------------

package m_decoder_operand_stage_pkg;

    // Value 0 is the reset value of the registered kind.
    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_RRR  = 2'd1,
        KIND_RRI  = 2'd2,
        KIND_SYS  = 2'd3
    } e_kind;

endpackage

module m_decoder_operand_stage
    import m_decoder_operand_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IMM_W  = 12,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,

    input  logic            in_valid,
    output logic            in_ready,
    input  e_kind           in_kind,
    input  logic [31:0]     in_instruction,

    output logic [4:0]      rs_sel,
    input  logic [XLEN-1:0] rs_in,
    output logic [4:0]      rq_sel,
    input  logic [XLEN-1:0] rq_in,

    input  logic            wb_en,
    input  logic [4:0]      wb_sel,
    input  logic [XLEN-1:0] wb_data,

    output logic            out_valid,
    input  logic            out_ready,
    output e_kind           out_kind,
    output logic [XLEN-1:0] out_val_a,
    output logic [XLEN-1:0] out_val_b,
    output logic [4:0]      out_rd
);

    // -----------------------------------------------------------------------
    // Field decode
    // -----------------------------------------------------------------------
    logic [4:0]      dec_rs;
    logic [4:0]      dec_rq;
    logic [4:0]      dec_rd;
    logic            use_rs;
    logic            use_rq;
    logic            use_imm;
    logic [XLEN-1:0] imm_ext;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_rs  = 5'd0;
        dec_rq  = 5'd0;
        dec_rd  = 5'd0;
        use_rs  = 1'b0;
        use_rq  = 1'b0;
        use_imm = 1'b0;
        case (in_kind)
            KIND_RRR: begin
                dec_rs = in_instruction[17:13];
                dec_rq = in_instruction[12:8];
                dec_rd = in_instruction[22:18];
                use_rs = 1'b1;
                use_rq = 1'b1;
            end
            KIND_RRI: begin
                dec_rs  = in_instruction[19:15];
                dec_rd  = in_instruction[24:20];
                use_rs  = 1'b1;
                use_imm = 1'b1;
            end
            default: begin
                // Non-register kinds carry no operands and no destination.
            end
        endcase
    end

    assign imm_ext = {{(XLEN-IMM_W){in_instruction[IMM_W-1]}},
                      in_instruction[IMM_W-1:0]};

    // The selects follow the instruction even when in_valid is low, so the
    // register file read is already settled when the instruction arrives.
    assign rs_sel = dec_rs;
    assign rq_sel = dec_rq;

    // Bits above the widest field are not part of any supported encoding.
    logic unused_instr_bits;
    assign unused_instr_bits = ^in_instruction[31:25];

    // -----------------------------------------------------------------------
    // Scoreboard lookup, bypass and hazard
    // -----------------------------------------------------------------------
    logic [31:0] scoreboard;

    logic rs_busy;
    logic rq_busy;
    logic rs_fwd;
    logic rq_fwd;
    logic rs_stall;
    logic rq_stall;
    logic hazard;

    // Register 0 is hard-wired to zero, so it is never pending.
    assign rs_busy = use_rs && (dec_rs != 5'd0) && scoreboard[dec_rs];
    assign rq_busy = use_rq && (dec_rq != 5'd0) && scoreboard[dec_rq];

    // A busy source is only released by a writeback to exactly that
    // register in this very cycle; anything else leaves it stalled.
    assign rs_fwd = (BYPASS != 0) && rs_busy && wb_en && (wb_sel == dec_rs);
    assign rq_fwd = (BYPASS != 0) && rq_busy && wb_en && (wb_sel == dec_rq);

    assign rs_stall = rs_busy && !rs_fwd;
    assign rq_stall = rq_busy && !rq_fwd;
    assign hazard   = rs_stall || rq_stall;

    // -----------------------------------------------------------------------
    // Operand selection
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] opnd_a;
    logic [XLEN-1:0] opnd_b;

    always_comb begin
        opnd_a = '0;
        if (use_rs && (dec_rs != 5'd0)) begin
            opnd_a = rs_fwd ? wb_data : rs_in;
        end

        opnd_b = '0;
        if (use_imm) begin
            opnd_b = imm_ext;
        end else if (use_rq && (dec_rq != 5'd0)) begin
            opnd_b = rq_fwd ? wb_data : rq_in;
        end
    end

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic accept;

    assign in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // Scoreboard next state
    // -----------------------------------------------------------------------
    logic [31:0] sb_set;
    logic [31:0] sb_clr;
    logic [31:0] sb_next;

    // dec_rd is already 0 for kinds without a destination.
    assign sb_set = (accept && (dec_rd != 5'd0)) ? (32'd1 << dec_rd) : 32'd0;
    assign sb_clr = (wb_en && (wb_sel != 5'd0)) ? (32'd1 << wb_sel) : 32'd0;

    // Set is applied after clear: a new pending write to the register that
    // is being written back right now must stay pending.
    assign sb_next = (scoreboard & ~sb_clr) | sb_set;

    // -----------------------------------------------------------------------
    // Output and scoreboard registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_kind   <= KIND_NONE;
            out_val_a  <= '0;
            out_val_b  <= '0;
            out_rd     <= 5'd0;
            scoreboard <= 32'd0;
        end else if (flush) begin
            // Data registers keep stale contents; out_valid guards them.
            out_valid  <= 1'b0;
            scoreboard <= 32'd0;
        end else begin
            scoreboard <= sb_next;
            if (accept) begin
                out_valid <= 1'b1;
                out_kind  <= in_kind;
                out_val_a <= opnd_a;
                out_val_b <= opnd_b;
                out_rd    <= dec_rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_m_decoder_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_m_decoder_operand_stage
//
// Two instances share every input: index 0 is built with BYPASS=0, index 1
// with BYPASS=1. A behavioural model of the stage (per instance) is stepped
// each cycle and compared against in_ready, the read selects and all
// registered outputs. On top of that a vector table and hand-written
// sequences compare against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_m_decoder_operand_stage;
    import m_decoder_operand_stage_pkg::*;

    localparam int XLEN  = 32;
    localparam int IMM_W = 12;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    e_kind           in_kind;
    logic [31:0]     in_instruction;
    logic            wb_en;
    logic [4:0]      wb_sel;
    logic [XLEN-1:0] wb_data;
    logic            out_ready;

    logic            in_ready_d  [2];
    logic [4:0]      rs_sel_d    [2];
    logic [4:0]      rq_sel_d    [2];
    logic [XLEN-1:0] rs_in_d     [2];
    logic [XLEN-1:0] rq_in_d     [2];
    logic            out_valid_d [2];
    e_kind           out_kind_d  [2];
    logic [XLEN-1:0] out_a_d     [2];
    logic [XLEN-1:0] out_b_d     [2];
    logic [4:0]      out_rd_d    [2];

    logic [XLEN-1:0] rf [32];

    int tests = 0;
    int fails = 0;

    // Model state, one copy per instance.
    bit              m_ov   [2];
    e_kind           m_kind [2];
    logic [XLEN-1:0] m_a    [2];
    logic [XLEN-1:0] m_b    [2];
    logic [4:0]      m_rd   [2];
    bit   [31:0]     m_sb   [2];

    assign rs_in_d[0] = rf[rs_sel_d[0]];
    assign rq_in_d[0] = rf[rq_sel_d[0]];
    assign rs_in_d[1] = rf[rs_sel_d[1]];
    assign rq_in_d[1] = rf[rq_sel_d[1]];

    m_decoder_operand_stage #(.XLEN(XLEN), .IMM_W(IMM_W), .BYPASS(0)) u_stall (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_d[0]), .in_kind(in_kind),
        .in_instruction(in_instruction),
        .rs_sel(rs_sel_d[0]), .rs_in(rs_in_d[0]),
        .rq_sel(rq_sel_d[0]), .rq_in(rq_in_d[0]),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .out_valid(out_valid_d[0]), .out_ready(out_ready),
        .out_kind(out_kind_d[0]), .out_val_a(out_a_d[0]),
        .out_val_b(out_b_d[0]), .out_rd(out_rd_d[0])
    );

    m_decoder_operand_stage #(.XLEN(XLEN), .IMM_W(IMM_W), .BYPASS(1)) u_bypass (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_d[1]), .in_kind(in_kind),
        .in_instruction(in_instruction),
        .rs_sel(rs_sel_d[1]), .rs_in(rs_in_d[1]),
        .rq_sel(rq_sel_d[1]), .rq_in(rq_in_d[1]),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .out_valid(out_valid_d[1]), .out_ready(out_ready),
        .out_kind(out_kind_d[1]), .out_val_a(out_a_d[1]),
        .out_val_b(out_b_d[1]), .out_rd(out_rd_d[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rrr(input int rs, input int rq, input int rd);
        return 32'((rd << 18) | (rs << 13) | (rq << 8));
    endfunction

    function automatic logic [31:0] rri(input int rs, input int rd, input int imm);
        return 32'((rd << 20) | (rs << 15) | imm);
    endfunction

    // Value of a register source as the stage must see it; flags a stall.
    function automatic logic [XLEN-1:0] src_val(input int b, input int s, output bit stall);
        bit busy;
        stall = 1'b0;
        if (s == 0) return '0;
        busy = m_sb[b][s];
        if (busy && b == 1 && wb_en && int'(wb_sel) == s) return wb_data;
        stall = busy;
        return rf[s];
    endfunction

    task automatic model_eval(input int b, output bit rdy,
                              output logic [4:0] ers, output logic [4:0] erq,
                              output logic [4:0] erd,
                              output logic [XLEN-1:0] ea, output logic [XLEN-1:0] eb);
        int     rs, rq, rd;
        bit     st_a, st_b;
        longint imm;
        rs = 0; rq = 0; rd = 0;
        st_a = 1'b0; st_b = 1'b0;
        ea = '0; eb = '0;
        case (in_kind)
            KIND_RRR: begin
                rs = int'((in_instruction >> 13) % 32);
                rq = int'((in_instruction >> 8) % 32);
                rd = int'((in_instruction >> 18) % 32);
                ea = src_val(b, rs, st_a);
                eb = src_val(b, rq, st_b);
            end
            KIND_RRI: begin
                rs  = int'((in_instruction >> 15) % 32);
                rd  = int'((in_instruction >> 20) % 32);
                ea  = src_val(b, rs, st_a);
                imm = longint'(in_instruction % (32'd1 << IMM_W));
                if (imm >= (longint'(1) << (IMM_W - 1))) imm -= (longint'(1) << IMM_W);
                eb  = imm[XLEN-1:0];
            end
            default: ;
        endcase
        ers = rs[4:0];
        erq = rq[4:0];
        erd = rd[4:0];
        rdy = !reset && !flush && !(st_a || st_b) && (!m_ov[b] || out_ready);
    endtask

    // Called right after inputs are applied (just after a negedge): checks
    // the combinational outputs, clocks once, updates the model and checks
    // the registered outputs, then returns at the next negedge.
    task automatic step();
        bit              rdy [2];
        logic [4:0]      ers [2], erq [2], erd [2];
        logic [XLEN-1:0] ea [2], eb [2];
        bit              was_reset;
        #2;
        for (int b = 0; b < 2; b++) begin
            model_eval(b, rdy[b], ers[b], erq[b], erd[b], ea[b], eb[b]);
            check($sformatf("in_ready[%0d]", b), in_ready_d[b], rdy[b]);
            check($sformatf("rs_sel[%0d]", b), rs_sel_d[b], ers[b]);
            check($sformatf("rq_sel[%0d]", b), rq_sel_d[b], erq[b]);
        end
        was_reset = reset;
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            if (reset) begin
                m_ov[b] = 1'b0; m_kind[b] = KIND_NONE;
                m_a[b] = '0; m_b[b] = '0; m_rd[b] = '0; m_sb[b] = '0;
            end else if (flush) begin
                m_ov[b] = 1'b0; m_sb[b] = '0;
            end else begin
                if (wb_en && wb_sel != 0) m_sb[b][wb_sel] = 1'b0;
                if (in_valid && rdy[b] && erd[b] != 0) m_sb[b][erd[b]] = 1'b1;
                if (in_valid && rdy[b]) begin
                    m_ov[b] = 1'b1; m_kind[b] = in_kind;
                    m_a[b] = ea[b]; m_b[b] = eb[b]; m_rd[b] = erd[b];
                end else if (out_ready) begin
                    m_ov[b] = 1'b0;
                end
            end
        end
        #1;
        for (int b = 0; b < 2; b++) begin
            check($sformatf("out_valid[%0d]", b), out_valid_d[b], m_ov[b]);
            if (m_ov[b] || was_reset) begin
                check($sformatf("out_kind[%0d]", b), out_kind_d[b], m_kind[b]);
                check($sformatf("out_val_a[%0d]", b), out_a_d[b], m_a[b]);
                check($sformatf("out_val_b[%0d]", b), out_b_d[b], m_b[b]);
                check($sformatf("out_rd[%0d]", b), out_rd_d[b], m_rd[b]);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic present(input e_kind k, input logic [31:0] instr);
        in_kind = k; in_instruction = instr; in_valid = 1'b1;
    endtask

    typedef struct {
        e_kind           kind;
        logic [31:0]     instr;
        logic [4:0]      rs;
        logic [4:0]      rq;
        logic [4:0]      rd;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } vec_t;

    vec_t vecs [7];

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = XLEN'($urandom);
        rf[0] = 32'hDEAD_BEEF;  // the stage must still read register 0 as 0
        rf[1] = 32'h1234_5678;
        rf[3] = 32'h11;
        rf[4] = 32'h22;
        rf[7] = 32'h7777_0007;

        vecs[0] = '{KIND_RRR,  rrr(3, 4, 5),        5'd3, 5'd4, 5'd5, 32'h11,        32'h22};
        vecs[1] = '{KIND_RRI,  rri(1, 2, 12'hFFF),  5'd1, 5'd0, 5'd2, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[2] = '{KIND_RRI,  rri(1, 2, 12'h7FF),  5'd1, 5'd0, 5'd2, 32'h1234_5678, 32'h0000_07FF};
        vecs[3] = '{KIND_RRI,  rri(0, 6, 12'h800),  5'd0, 5'd0, 5'd6, 32'h0,         32'hFFFF_F800};
        vecs[4] = '{KIND_RRR,  rrr(0, 0, 0),        5'd0, 5'd0, 5'd0, 32'h0,         32'h0};
        vecs[5] = '{KIND_SYS,  32'hFFFF_FFFF,       5'd0, 5'd0, 5'd0, 32'h0,         32'h0};
        vecs[6] = '{KIND_NONE, 32'h5A5A_A5A5,       5'd0, 5'd0, 5'd0, 32'h0,         32'h0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_kind = KIND_NONE;
        in_instruction = '0; wb_en = 1'b0; wb_sel = '0; wb_data = '0; out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            m_ov[b] = 1'b0; m_kind[b] = KIND_NONE; m_a[b] = '0; m_b[b] = '0;
            m_rd[b] = '0; m_sb[b] = '0;
        end
        @(negedge clk);

        // Reset state.
        do_reset();
        for (int b = 0; b < 2; b++) begin
            check("reset_out_valid", out_valid_d[b], 1'b0);
            check("reset_out_kind", out_kind_d[b], KIND_NONE);
            check("reset_out_val_a", out_a_d[b], '0);
            check("reset_out_rd", out_rd_d[b], '0);
        end

        // Vector table: decode, register-0 handling, sign extension.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            present(vecs[i].kind, vecs[i].instr);
            #1;
            for (int b = 0; b < 2; b++) begin
                check($sformatf("vec%0d_rs_sel", i), rs_sel_d[b], vecs[i].rs);
                check($sformatf("vec%0d_rq_sel", i), rq_sel_d[b], vecs[i].rq);
            end
            step();
            for (int b = 0; b < 2; b++) begin
                check($sformatf("vec%0d_valid", i), out_valid_d[b], 1'b1);
                check($sformatf("vec%0d_kind", i), out_kind_d[b], vecs[i].kind);
                check($sformatf("vec%0d_val_a", i), out_a_d[b], vecs[i].a);
                check($sformatf("vec%0d_val_b", i), out_b_d[b], vecs[i].b);
                check($sformatf("vec%0d_rd", i), out_rd_d[b], vecs[i].rd);
            end
            in_valid = 1'b0;
            step();
        end

        // Scoreboard bit 5 set by the first RRR blocks a reader of r5.
        do_reset();
        present(KIND_RRR, rrr(3, 4, 5));
        step();
        present(KIND_RRR, rrr(5, 0, 0));
        #1;
        check("sb5_block_stall", in_ready_d[0], 1'b0);
        check("sb5_block_bypass", in_ready_d[1], 1'b0);
        step();
        in_valid = 1'b0;
        step();

        // RAW on r7: stall until writeback vs. same-cycle bypass.
        do_reset();
        present(KIND_RRI, rri(1, 7, 5));
        step();
        present(KIND_RRR, rrr(7, 0, 1));
        #1;
        check("raw7_wait_stall", in_ready_d[0], 1'b0);
        check("raw7_wait_bypass", in_ready_d[1], 1'b0);
        step();
        wb_en = 1'b1; wb_sel = 5'd7; wb_data = 32'h0000_ABCD;
        #1;
        check("raw7_wb_ready_bypass", in_ready_d[1], 1'b1);
        check("raw7_wb_ready_stall", in_ready_d[0], 1'b0);
        step();
        check("raw7_bypass_valid", out_valid_d[1], 1'b1);
        check("raw7_bypass_val_a", out_a_d[1], 32'h0000_ABCD);
        check("raw7_bypass_rd", out_rd_d[1], 5'd1);
        check("raw7_stall_valid", out_valid_d[0], 1'b0);
        wb_en = 1'b0;
        #1;
        check("raw7_after_wb_ready_stall", in_ready_d[0], 1'b1);
        step();
        check("raw7_stall_accept_valid", out_valid_d[0], 1'b1);
        check("raw7_stall_val_a", out_a_d[0], 32'h7777_0007);
        in_valid = 1'b0;
        step();

        // Backpressure: held outputs stay put, nothing lost or duplicated.
        do_reset();
        out_ready = 1'b0;
        present(KIND_RRR, rrr(3, 4, 0));
        step();
        present(KIND_RRR, rrr(4, 3, 0));
        for (int c = 0; c < 3; c++) begin
            #1;
            for (int b = 0; b < 2; b++) check("bp_in_ready", in_ready_d[b], 1'b0);
            step();
            for (int b = 0; b < 2; b++) begin
                check("bp_hold_valid", out_valid_d[b], 1'b1);
                check("bp_hold_val_a", out_a_d[b], 32'h11);
                check("bp_hold_val_b", out_b_d[b], 32'h22);
            end
        end
        out_ready = 1'b1;
        #1;
        for (int b = 0; b < 2; b++) check("bp_release_ready", in_ready_d[b], 1'b1);
        step();
        for (int b = 0; b < 2; b++) begin
            check("bp_next_val_a", out_a_d[b], 32'h22);
            check("bp_next_val_b", out_b_d[b], 32'h11);
        end
        in_valid = 1'b0;
        step();
        for (int b = 0; b < 2; b++) check("bp_no_dup", out_valid_d[b], 1'b0);

        // Set wins over a same-cycle clear; writeback to r0 changes nothing.
        do_reset();
        present(KIND_RRI, rri(0, 9, 1));
        wb_en = 1'b1; wb_sel = 5'd9; wb_data = 32'hCAFE_0009;
        step();
        wb_en = 1'b0;
        present(KIND_RRR, rrr(9, 0, 0));
        #1;
        for (int b = 0; b < 2; b++) check("set_wins_r9_busy", in_ready_d[b], 1'b0);
        step();
        in_valid = 1'b0;
        wb_en = 1'b1; wb_sel = 5'd0;
        step();
        wb_en = 1'b0;
        present(KIND_RRR, rrr(9, 0, 0));
        #1;
        for (int b = 0; b < 2; b++) check("wb_r0_keeps_r9", in_ready_d[b], 1'b0);
        step();
        present(KIND_RRR, rrr(0, 0, 0));
        step();
        #1;
        for (int b = 0; b < 2; b++) check("rd0_never_busy", in_ready_d[b], 1'b1);
        in_valid = 1'b0;
        step();

        // Flush with a held output and bits 5 and 9 pending.
        do_reset();
        present(KIND_RRR, rrr(1, 2, 5));
        step();
        present(KIND_RRI, rri(1, 9, 3));
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        for (int b = 0; b < 2; b++) check("flush_in_ready", in_ready_d[b], 1'b0);
        step();
        flush = 1'b0;
        for (int b = 0; b < 2; b++) check("flush_out_valid", out_valid_d[b], 1'b0);
        present(KIND_RRR, rrr(5, 9, 0));
        #1;
        for (int b = 0; b < 2; b++) check("flush_sb_clear", in_ready_d[b], 1'b1);
        step();
        in_valid = 1'b0;
        step();

        // Reset in the middle of a stall.
        do_reset();
        present(KIND_RRI, rri(1, 7, 2));
        step();
        out_ready = 1'b0;
        present(KIND_RRR, rrr(7, 3, 0));
        step();
        reset = 1'b1;
        #1;
        for (int b = 0; b < 2; b++) check("stall_reset_in_ready", in_ready_d[b], 1'b0);
        step();
        for (int b = 0; b < 2; b++) begin
            check("stall_reset_valid", out_valid_d[b], 1'b0);
            check("stall_reset_kind", out_kind_d[b], KIND_NONE);
            check("stall_reset_val_a", out_a_d[b], '0);
            check("stall_reset_val_b", out_b_d[b], '0);
            check("stall_reset_rd", out_rd_d[b], '0);
        end
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int b = 0; b < 2; b++) check("stall_reset_sb_clear", in_ready_d[b], 1'b1);
        step();
        in_valid = 1'b0;
        step();

        // Randomised traffic against the model.
        for (int i = 0; i < 32; i++) rf[i] = XLEN'($urandom);
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 127) == 0);
            flush          = ($urandom_range(0, 31) == 0);
            in_valid       = ($urandom_range(0, 3) != 0);
            in_kind        = e_kind'($urandom_range(0, 3));
            in_instruction = $urandom;
            wb_en          = ($urandom_range(0, 1) == 1);
            wb_sel         = 5'($urandom_range(0, 31));
            wb_data        = XLEN'($urandom);
            out_ready      = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/m_decoder_operand_stage.md
Name: m_decoder_operand_stage

Overview:
- Registered operand-fetch stage between the decoder and execute, with a valid/ready handshake on both sides.
- Decodes instruction kind and register fields, then reads the register file through two read ports.
- Sign-extends immediates to XLEN and tracks pending destination writes in a scoreboard so that a read-after-write hazard either stalls or is bypassed from writeback.
- Parametrised in data width, immediate width and bypass mode.

Parameters:
- XLEN, 32, operand/register data width.
- IMM_W, 12, RRI immediate width, taken from instruction[IMM_W-1:0]; legal range 1..15.
- BYPASS, 1, 1 = forward same-cycle writeback data into operands; 0 = stall until the scoreboard bit clears.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard the held output and clear the scoreboard.
- in_valid  in  1  decoder has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_kind  in  e_kind  instruction kind.
- in_instruction  in  32  raw instruction.
- rs_sel  out  5  register-file read port A select.
- rs_in  in  XLEN  port A data (combinational read).
- rq_sel  out  5  register-file read port B select.
- rq_in  in  XLEN  port B data.
- wb_en  in  1  writeback strobe.
- wb_sel  in  5  writeback register.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  operands held.
- out_ready  in  1  execute accepts.
- out_kind  out  e_kind  registered kind.
- out_val_a  out  XLEN  operand A.
- out_val_b  out  XLEN  operand B.
- out_rd  out  5  destination register.

Behaviour:
- Field decode (combinational, from in_instruction):
  - RRR: rs = [17:13], rq = [12:8], rd = [22:18].
  - RRI: rs = [19:15], rd = [24:20], imm = [IMM_W-1:0].
  - Any other kind: all selects 0, both operands 0, rd 0.
- Operand selection:
  - RRR: A = port A, B = port B.
  - RRI: A = port A, B = imm sign-extended from bit IMM_W-1 to XLEN.
- Register 0 reads as 0, is never busy, and is never marked in the scoreboard.
- A used source is busy when its scoreboard bit is set.
- With BYPASS=1, a busy source is cleared for this cycle when wb_en is high and wb_sel equals that select; the operand then takes wb_data instead of the port data.
- hazard = any used source still busy after the bypass check. An unused source (rq for RRI) is never checked.
- in_ready = !reset && !flush && !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, next cycle: out_valid=1 and out_kind/out_val_a/out_val_b/out_rd are registered. Latency is 1 cycle.
- If out_valid && !out_ready, all out_* hold stable.
- If out_valid && out_ready && no accept, out_valid drops to 0.
- Scoreboard (32 bits):
  - On accept of RRR/RRI with rd != 0, set bit rd.
  - On wb_en with wb_sel != 0, clear bit wb_sel.
  - Same register set and cleared in one cycle: set wins (the new write is pending).
  - wb_en on a register that is not busy is ignored.
- flush (priority over accept): next cycle out_valid=0 and scoreboard all-zero. Output data registers may keep stale values.
- reset: out_valid=0, out_kind=default enum value 0, out_val_a=0, out_val_b=0, out_rd=0, scoreboard=0. in_ready is 0 while reset is high.
- Reset or flush in the middle of a stall drops the pending instruction; the decoder must re-present it.
- rs_sel/rq_sel are driven combinationally from in_instruction regardless of in_valid.

Test Plan:
- Reset, then RRR rs=3, rq=4, rd=5 with r3=0x11, r4=0x22, out_ready=1 -> 1 cycle later out_valid=1, val_a=0x11, val_b=0x22, rd=5, scoreboard bit5=1.
- RRI rs=1, imm=0xFFF (IMM_W=12), XLEN=32 -> val_b=0xFFFFFFFF. Repeat with imm=0x7FF -> val_b=0x000007FF.
- RRI rd=7, then RRR using rs=7 with no writeback:
  - BYPASS=0 -> in_ready=0 until wb_en, wb_sel=7, then accepted the following cycle.
  - BYPASS=1 with wb_en, wb_sel=7, wb_data=0xABCD in the same cycle -> accepted, val_a=0xABCD.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> outputs stable, in_ready=0; release -> next instruction appears the following cycle with no loss or duplication.
- In one cycle, accept with rd=9 while wb_en, wb_sel=9 -> scoreboard bit9 remains 1. Writeback to r0 -> no scoreboard change. An rd=0 instruction -> no bit set.
- flush with out_valid=1 and bits 5 and 9 busy -> out_valid=0 and scoreboard=0 next cycle. Assert reset during a stall -> all outputs at reset values and in_ready=0.
